key_event: RTL and testbench



---
 rtl/key_event.sv | 157 +++++++++++++++
 tb/tb_key_event.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_event.sv
// key_event: press/release/long-press event unit for a debounced active-low key, Wishbone registers.
// Define KEY_EVENT_IRQ_EN to implement the CTRL enables and the o_irq line (otherwise CTRL reads 0, o_irq = 0).
module key_event #(
  parameter int ASIZE     = 2,
  parameter int DSIZE     = 8,
  parameter int PRESC_DIV = 100000,
  parameter int LONG_DEF  = 100
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [ASIZE-1:0] i_wb_adr,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [DSIZE-1:0] i_wb_dat,
  input  logic             i_key_n,
  output logic             o_wb_ack,
  output logic [DSIZE-1:0] o_wb_dat,
  output logic             o_irq
);

  // state   | meaning
  // IDLE    | key released, waiting for a press
  // PRESSED | key held, duration being timed
  // LONG    | key held, long press already flagged
  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

  localparam int               PW         = $clog2(PRESC_DIV);
  localparam logic [PW-1:0]    PRESC_TOP  = PW'(PRESC_DIV - 1);
  localparam logic [DSIZE-1:0] DUR_MAX    = '1;

  state_t           state, state_nxt;
  logic             key_q, armed, press_q, rel_q;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [DSIZE-1:0] dur, dur_inc, long_thr, last_dur, rd_data;
  logic [2:0]       st_flags, ev_set, ctrl;
  logic             st_ovf, ovf_hit;
  logic [3:0]       w1c;
  logic             rd_en, wr_en;

  assign rd_en   = i_wb_stb & ~o_wb_ack;
  assign wr_en   = rd_en & i_wb_we;
  assign w1c     = (wr_en && i_wb_adr == ASIZE'(0)) ? i_wb_dat[3:0] : 4'b0;
  assign tick    = (presc == '0);
  assign dur_inc = (tick && dur != DUR_MAX) ? dur + 1'b1 : dur;

  // A key held through reset must be released once before a press counts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      key_q   <= 1'b1;
      armed   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      key_q   <= i_key_n;
      armed   <= armed | i_key_n;
      press_q <= key_q & ~i_key_n & armed;
      rel_q   <= ~key_q & i_key_n;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ev_set    = 3'b0;
    case (state)
      IDLE: begin
        if (press_q) begin
          state_nxt = PRESSED;
          ev_set[0] = 1'b1;
        end
      end
      PRESSED: begin
        if (rel_q) begin
          state_nxt = IDLE;
          ev_set[1] = 1'b1;
        end else if (long_thr != '0 && dur == long_thr) begin
          state_nxt = LONG;
          ev_set[2] = 1'b1;
        end
      end
      LONG: begin
        if (rel_q) begin
          state_nxt = IDLE;
          ev_set[1] = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Down-counting prescaler; reloading on press puts the first tick PRESC_DIV clocks later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc    <= '0;
      dur      <= '0;
      last_dur <= '0;
    end else begin
      if (ev_set[0] || tick) presc <= PRESC_TOP;
      else                   presc <= presc - 1'b1;
      if (ev_set[0])          dur <= '0;
      else if (state != IDLE) dur <= dur_inc;
      if (ev_set[1]) last_dur <= dur_inc;
    end
  end

  assign ovf_hit = |(ev_set & st_flags & ~w1c[2:0]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_flags <= 3'b0;
      st_ovf   <= 1'b0;
      long_thr <= DSIZE'(LONG_DEF);
    end else begin
      st_flags <= (st_flags & ~w1c[2:0]) | ev_set;
      st_ovf   <= (st_ovf & ~w1c[3]) | ovf_hit;
      if (wr_en && i_wb_adr == ASIZE'(2)) long_thr <= i_wb_dat;
    end
  end

`ifdef KEY_EVENT_IRQ_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                            ctrl <= 3'b0;
    else if (wr_en && i_wb_adr == ASIZE'(1)) ctrl <= i_wb_dat[2:0];
  end
  assign o_irq = |(st_flags & ctrl);
`else
  assign ctrl  = 3'b0;
  assign o_irq = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (i_wb_adr)
      ASIZE'(0): rd_data[4:0] = {state != IDLE, st_ovf, st_flags};
      ASIZE'(1): rd_data[2:0] = ctrl;
      ASIZE'(2): rd_data      = long_thr;
      ASIZE'(3): rd_data      = last_dur;
      default:   rd_data      = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      o_wb_ack <= rd_en;
      if (rd_en) o_wb_dat <= rd_data;
    end
  end

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed stimulus for key_event with a timestamp-based event model checked every cycle.
module tb_key_event;
  localparam int ASIZE    = 2;
  localparam int DSIZE    = 8;
  localparam int PRESC    = 4;
  localparam int LONG_DEF = 100;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [1:0] i_wb_adr = 2'd0;
  logic       i_wb_stb = 1'b0;
  logic       i_wb_we = 1'b0;
  logic [7:0] i_wb_dat = 8'd0;
  logic       i_key_n = 1'b1;
  logic       o_wb_ack;
  logic [7:0] o_wb_dat;
  logic       o_irq;

  int n_chk = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  key_event #(.ASIZE(ASIZE), .DSIZE(DSIZE), .PRESC_DIV(PRESC), .LONG_DEF(LONG_DEF)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wb_adr(i_wb_adr), .i_wb_stb(i_wb_stb),
    .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat), .i_key_n(i_key_n),
    .o_wb_ack(o_wb_ack), .o_wb_dat(o_wb_dat), .o_irq(o_irq)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: events are timestamped in clock edges; durations come from edge differences.
  int         cyc, p_edge, held;
  logic       m_press, m_rel, m_long, m_ovf, m_level, m_long_done;
  logic       m_ack, m_armed, m_key_prev, m_pend_press, m_pend_rel;
  logic [2:0] m_ctrl;
  logic [7:0] m_thr, m_last, m_dat;
  logic       rd, wr, e_press, e_rel, e_long, ovf_hit;
  logic [3:0] w1c;
  wire        m_irq = |({m_long, m_rel, m_press} & m_ctrl);

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {3'b0, m_level, m_ovf, m_long, m_rel, m_press};
      2'd1:    return {5'b0, m_ctrl};
      2'd2:    return m_thr;
      default: return m_last;
    endcase
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cyc = 0; p_edge = 0;
      m_press = 0; m_rel = 0; m_long = 0; m_ovf = 0; m_level = 0; m_long_done = 0;
      m_ack = 0; m_armed = 0; m_key_prev = 1; m_pend_press = 0; m_pend_rel = 0;
      m_ctrl = 0; m_thr = 8'(LONG_DEF); m_last = 0; m_dat = 0;
    end else begin
      cyc++;
      rd = i_wb_stb && !m_ack;
      wr = rd && i_wb_we;
      if (rd) m_dat = m_read(i_wb_adr);
      e_press = m_pend_press && !m_level;
      e_rel   = m_pend_rel && m_level;
      e_long  = m_level && !m_long_done && (m_thr != 0) && !e_rel &&
                (cyc == p_edge + 1 + PRESC * int'(m_thr));
      w1c = (wr && i_wb_adr == 2'd0) ? i_wb_dat[3:0] : 4'h0;
      ovf_hit = (e_press && m_press && !w1c[0]) || (e_rel && m_rel && !w1c[1]) ||
                (e_long && m_long && !w1c[2]);
      m_press = (m_press && !w1c[0]) || e_press;
      m_rel   = (m_rel && !w1c[1]) || e_rel;
      m_long  = (m_long && !w1c[2]) || e_long;
      m_ovf   = (m_ovf && !w1c[3]) || ovf_hit;
      if (e_press) begin m_level = 1; p_edge = cyc; m_long_done = 0; end
      if (e_rel) begin
        m_level = 0;
        held = (cyc - p_edge) / PRESC;
        m_last = (held > 255) ? 8'hFF : 8'(held);
      end
      if (e_long) m_long_done = 1;
      if (wr && i_wb_adr == 2'd2) m_thr = i_wb_dat;
`ifdef KEY_EVENT_IRQ_EN
      if (wr && i_wb_adr == 2'd1) m_ctrl = i_wb_dat[2:0];
`endif
      m_ack = rd;
      m_pend_press = m_armed && m_key_prev && !i_key_n;
      m_pend_rel   = !m_key_prev && i_key_n;
      m_armed      = m_armed || i_key_n;
      m_key_prev   = i_key_n;
    end
  end

  always @(posedge i_clk) begin
    #1;
    if (i_rst_n) begin
      check("ack", o_wb_ack, m_ack);
      check("irq", o_irq, m_irq);
      if (m_ack) check("rdata", o_wb_dat, m_dat);
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
    i_wb_adr = a; i_wb_dat = v; i_wb_we = 1'b1; i_wb_stb = 1'b1;
    @(negedge i_clk);
    i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] v);
    i_wb_adr = a; i_wb_we = 1'b0; i_wb_stb = 1'b1;
    @(negedge i_clk);
    v = o_wb_dat; i_wb_stb = 1'b0;
    @(negedge i_clk);
  endtask

  logic [7:0] d;
  int first_long;

  initial begin
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    bus_read(2'd0, d); check("rst_status", d, 8'h00);
    bus_read(2'd1, d); check("rst_ctrl", d, 8'h00);
    bus_read(2'd2, d); check("rst_thr", d, LONG_DEF);
    bus_read(2'd3, d); check("rst_last", d, 8'h00);
    check("rst_irq", o_irq, 0);

    // short press, threshold 10: no LONG, duration 22 clocks -> 5 ticks
    bus_write(2'd2, 8'd10);
    i_key_n = 1'b0;
    @(negedge i_clk);
    bus_read(2'd0, d); check("press_lat_n1", d, 8'h00);
    bus_read(2'd0, d); check("press_status", d, 8'h11);
    repeat (17) @(negedge i_clk);
    i_key_n = 1'b1;
    @(negedge i_clk);
    bus_read(2'd0, d); check("release_lat_n1", d, 8'h11);
    bus_read(2'd0, d); check("release_status", d, 8'h03);
    bus_read(2'd3, d); check("last_dur_22", d, 8'd5);
    bus_write(2'd0, 8'h0F);
    bus_read(2'd0, d); check("clear_all", d, 8'h00);

    // long press, threshold 3, polled at both read phases
    bus_write(2'd2, 8'd3);
    for (int ph = 0; ph < 2; ph++) begin
      first_long = -1;
      i_key_n = 1'b0;
      if (ph == 1) @(negedge i_clk);
      for (int i = 0; i < 20; i++) begin
        bus_read(2'd0, d);
        if (d[2] && first_long < 0) first_long = i;
      end
      i_key_n = 1'b1;
      check(ph == 0 ? "long_idx_ph0" : "long_idx_ph1", first_long, ph == 0 ? 8 : 7);
      repeat (3) @(negedge i_clk);
      bus_read(2'd0, d); check("long_status", d, 8'h07);
      bus_read(2'd3, d); check("last_dur_long", d, 8'd10);
      bus_write(2'd0, 8'h0F);
    end

    // overflow from two uncleared presses
    for (int i = 0; i < 2; i++) begin
      i_key_n = 1'b0; repeat (4) @(negedge i_clk);
      i_key_n = 1'b1; repeat (4) @(negedge i_clk);
    end
    bus_read(2'd0, d); check("ovf_status", d, 8'h0B);
    bus_write(2'd0, 8'h0F);
    bus_read(2'd0, d); check("ovf_clear", d, 8'h00);
    i_key_n = 1'b0; repeat (4) @(negedge i_clk);
    i_key_n = 1'b1; repeat (4) @(negedge i_clk);
    bus_read(2'd0, d); check("pre_race", d, 8'h03);
    // W1C of PRESS lands on the same edge the new press is flagged
    i_key_n = 1'b0;
    @(negedge i_clk);
    bus_write(2'd0, 8'h01);
    bus_read(2'd0, d); check("set_wins", d, 8'h13);
    i_key_n = 1'b1; repeat (4) @(negedge i_clk);
    bus_write(2'd0, 8'h0F);

`ifdef KEY_EVENT_IRQ_EN
    bus_write(2'd1, 8'h02);
    bus_read(2'd1, d); check("ctrl_rb", d, 8'h02);
    i_key_n = 1'b0; repeat (6) @(negedge i_clk);
    check("irq_press", o_irq, 0);
    i_key_n = 1'b1;
    @(negedge i_clk); check("irq_rel_n1", o_irq, 0);
    @(negedge i_clk); check("irq_rel", o_irq, 1);
    i_wb_adr = 2'd0; i_wb_dat = 8'h02; i_wb_we = 1'b1; i_wb_stb = 1'b1;
    @(negedge i_clk);
    check("irq_clr_ack", o_wb_ack, 1);
    check("irq_clr", o_irq, 0);
    i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(negedge i_clk);
    bus_write(2'd1, 8'h00);
`else
    bus_write(2'd1, 8'h07);
    bus_read(2'd1, d); check("ctrl_ro", d, 8'h00);
    i_key_n = 1'b0; repeat (6) @(negedge i_clk);
    i_key_n = 1'b1; repeat (3) @(negedge i_clk);
    check("irq_off", o_irq, 0);
`endif
    bus_write(2'd0, 8'h0F);

    // reset mid-press: held key ignored until released
    i_key_n = 1'b0; repeat (10) @(negedge i_clk);
    i_rst_n = 1'b0; repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1; repeat (6) @(negedge i_clk);
    bus_read(2'd0, d); check("rst_mid_status", d, 8'h00);
    bus_read(2'd2, d); check("rst_mid_thr", d, LONG_DEF);
    i_key_n = 1'b1; repeat (4) @(negedge i_clk);
    bus_read(2'd0, d); check("rst_release_ignored", d, 8'h00);
    i_key_n = 1'b0; repeat (4) @(negedge i_clk);
    bus_read(2'd0, d); check("resume_press", d, 8'h11);
    i_key_n = 1'b1; repeat (4) @(negedge i_clk);
    bus_read(2'd0, d); check("resume_release", d, 8'h03);
    bus_read(2'd3, d); check("resume_dur", d, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
